// File: rtl/keypad_scanner_if.sv
// Signal bundle between the key matrix, the keypad scanner and its downstream consumer.
// The scanner is the master: it drives the columns and the debounced key outputs.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [4:0] col_n;
  logic [4:0] key_code;
  logic       key_valid;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x5 key matrix scanner with per-scan classification and a press/release debounce FSM.
// key_valid is a level that stays high while a debounced key is held; key_code is latched on acceptance.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int              SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [7:0]      DB        = 8'(DEBOUNCE_SCANS);
  localparam logic [4:0]      CODE_NOP  = 5'b10110;
  localparam logic [1:0]      RES_NONE   = 2'd0;
  localparam logic [1:0]      RES_SINGLE = 2'd1;
  localparam logic [1:0]      RES_MULTI  = 2'd2;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  function automatic logic [4:0] key_map(input logic [4:0] idx);
    case (idx)
      5'd0:    key_map = 5'b00111;
      5'd1:    key_map = 5'b01000;
      5'd2:    key_map = 5'b01001;
      5'd3:    key_map = 5'b10000;
      5'd4:    key_map = 5'b10100;
      5'd5:    key_map = 5'b00100;
      5'd6:    key_map = 5'b00101;
      5'd7:    key_map = 5'b00110;
      5'd8:    key_map = 5'b10001;
      5'd9:    key_map = 5'b10101;
      5'd10:   key_map = 5'b00001;
      5'd11:   key_map = 5'b00010;
      5'd12:   key_map = 5'b00011;
      5'd13:   key_map = 5'b10010;
      5'd15:   key_map = 5'b00000;
      5'd18:   key_map = 5'b10011;
      default: key_map = CODE_NOP;
    endcase
  endfunction

  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [SW-1:0] slot;
  logic [2:0]    col;
  logic [4:0]    col_drive;
  logic [1:0]    acc_hits;
  logic [4:0]    acc_idx;
  logic          res_valid;
  logic [1:0]    res_kind;
  logic [4:0]    res_idx;

  logic [2:0]    lows;
  logic [1:0]    low_row;
  logic [2:0]    sum_hits;
  logic [1:0]    merged_kind;
  logic [4:0]    merged_idx;

  state_t        state, state_nx;
  logic [7:0]    cnt, cnt_nx;
  logic [4:0]    cand, cand_nx;
  logic [4:0]    code, code_nx;
  logic          valid, valid_nx;

  // Fold the current slot's row sample into the running scan classification.
  always_comb begin
    lows    = 3'd0;
    low_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      lows = lows + {2'b00, ~row_s[r]};
      if (!row_s[r]) begin
        low_row = 2'(r);
      end else begin
        low_row = low_row;
      end
    end
    sum_hits = {1'b0, acc_hits} + lows;
    if (sum_hits == 3'd0) begin
      merged_kind = RES_NONE;
    end else if (sum_hits == 3'd1) begin
      merged_kind = RES_SINGLE;
    end else begin
      merged_kind = RES_MULTI;
    end
    if (acc_hits == 2'd0) begin
      merged_idx = 5'({3'b000, low_row} * 5'd5) + {2'b00, col};
    end else begin
      merged_idx = acc_idx;
    end
  end

  // Row synchronizer, slot/column walk and per-scan result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_m     <= 4'b1111;
      row_s     <= 4'b1111;
      slot      <= '0;
      col       <= 3'd0;
      col_drive <= 5'b11110;
      acc_hits  <= 2'd0;
      acc_idx   <= 5'd0;
      res_valid <= 1'b0;
      res_kind  <= RES_NONE;
      res_idx   <= 5'd0;
    end else begin
      row_m     <= kp.row_n;
      row_s     <= row_m;
      res_valid <= 1'b0;
      if (slot == SLOT_LAST) begin
        slot      <= '0;
        col_drive <= {col_drive[3:0], col_drive[4]};
        if (col == 3'd4) begin
          col       <= 3'd0;
          res_valid <= 1'b1;
          res_kind  <= merged_kind;
          res_idx   <= merged_idx;
          acc_hits  <= 2'd0;
          acc_idx   <= 5'd0;
        end else begin
          col      <= col + 3'd1;
          acc_hits <= (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
          acc_idx  <= merged_idx;
        end
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  // Debounce FSM: only advances on the cycle a scan result is available.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    code_nx  = code;
    valid_nx = valid;
    if (res_valid) begin
      case (state)
        IDLE: begin
          if (res_kind == RES_SINGLE) begin
            cand_nx = res_idx;
            cnt_nx  = 8'd1;
            if (DB == 8'd1) begin
              state_nx = PRESSED;
              code_nx  = key_map(res_idx);
              valid_nx = 1'b1;
            end else begin
              state_nx = DEBOUNCE;
            end
          end else begin
            state_nx = IDLE;
          end
        end
        DEBOUNCE: begin
          if (res_kind == RES_SINGLE && res_idx == cand) begin
            cnt_nx = cnt + 8'd1;
            if (cnt + 8'd1 == DB) begin
              state_nx = PRESSED;
              code_nx  = key_map(cand);
              valid_nx = 1'b1;
            end else begin
              state_nx = DEBOUNCE;
            end
          end else if (res_kind == RES_SINGLE) begin
            cand_nx = res_idx;
            cnt_nx  = 8'd1;
          end else begin
            state_nx = IDLE;
          end
        end
        PRESSED: begin
          if (res_kind == RES_NONE) begin
            cnt_nx = 8'd1;
            if (DB == 8'd1) begin
              state_nx = IDLE;
              valid_nx = 1'b0;
            end else begin
              state_nx = RELEASE;
            end
          end else begin
            state_nx = PRESSED;
          end
        end
        RELEASE: begin
          if (res_kind == RES_NONE) begin
            cnt_nx = cnt + 8'd1;
            if (cnt + 8'd1 == DB) begin
              state_nx = IDLE;
              valid_nx = 1'b0;
            end else begin
              state_nx = RELEASE;
            end
          end else begin
            state_nx = PRESSED;
          end
        end
        default: begin
          state_nx = IDLE;
          valid_nx = 1'b0;
        end
      endcase
    end else begin
      state_nx = state;
    end
  end

  // FSM state and registered key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      cand  <= 5'd0;
      code  <= CODE_NOP;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
      code  <= code_nx;
      valid <= valid_nx;
    end
  end

  assign kp.col_n     = col_drive;
  assign kp.key_code  = code;
  assign kp.key_valid = valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives the rows, a scoreboard holds expected codes
// and a monitor checks each key_valid rising edge against the next expected code.
module tb_keypad_scanner;

  localparam logic [4:0] CODE_NOP = 5'b10110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] pressed = 20'd0;
  logic [3:0]  row_model;
  int          checks = 0;
  int          errors = 0;
  int          rises = 0;
  logic        prev_valid = 1'b0;
  logic [4:0]  mon_exp;
  logic [4:0]  exp_q[$];

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row is pulled low when a pressed key sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_model[r] = ~|(pressed[r*5 +: 5] & ~kif.col_n);
    end
  end
  assign kif.row_n = row_model;

  // Every accepted press must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (kif.key_valid === 1'b1 && prev_valid === 1'b0) begin
      rises = rises + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_press: key_code=%b, no press expected", kif.key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (kif.key_code !== mon_exp) begin
          errors = errors + 1;
          $display("FAIL press_code: got %b expected %b", kif.key_code, mon_exp);
        end
      end
    end
    prev_valid = kif.key_valid;
  end

  task automatic wait_col_start(input logic [4:0] target);
    int n = 0;
    while (kif.col_n === target && n < 30) begin
      @(negedge clk);
      n++;
    end
    while (kif.col_n !== target && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (kif.col_n !== target) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL col_wait_timeout: col_n=%b expected %b", kif.col_n, target);
    end
  endtask

  task automatic wait_valid(input logic level, input int budget, output int n);
    n = 0;
    while (kif.key_valid !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [4:0] one_hot;
    logic [4:0] exp_col;
    rst = 1'b1;
    pressed = 20'd0;
    repeat (2) @(negedge clk);
    checks = checks + 3;
    if (kif.col_n !== 5'b11110) begin
      errors = errors + 1;
      $display("FAIL reset_col_n: got %b expected 11110", kif.col_n);
    end
    if (kif.key_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_key_valid: got %b expected 0", kif.key_valid);
    end
    if (kif.key_code !== CODE_NOP) begin
      errors = errors + 1;
      $display("FAIL reset_key_code: got %b expected %b", kif.key_code, CODE_NOP);
    end
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      one_hot = 5'b00001 << ((i / 4) % 5);
      exp_col = ~one_hot;
      checks = checks + 1;
      if (kif.col_n !== exp_col) begin
        errors = errors + 1;
        $display("FAIL col_walk[%0d]: got %b expected %b", i, kif.col_n, exp_col);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_press();
    int n;
    wait_col_start(5'b11101);
    pressed[6] = 1'b1;
    exp_q.push_back(5'b00101);
    wait_valid(1'b1, 70, n);
    checks = checks + 1;
    if (kif.key_valid !== 1'b1 || n < 43 || n > 63) begin
      errors = errors + 1;
      $display("FAIL key5_rise_latency: valid=%b after %0d cycles, required 43..63", kif.key_valid, n);
    end
    repeat (200 - n) @(negedge clk);
    checks = checks + 1;
    if (kif.key_valid !== 1'b1 || kif.key_code !== 5'b00101) begin
      errors = errors + 1;
      $display("FAIL key5_hold: valid=%b code=%b, required 1/00101", kif.key_valid, kif.key_code);
    end
    wait_col_start(5'b11110);
    pressed = 20'd0;
    wait_valid(1'b0, 90, n);
    checks = checks + 1;
    if (kif.key_valid !== 1'b0 || n < 43 || n > 83) begin
      errors = errors + 1;
      $display("FAIL key5_release: valid=%b after %0d cycles, required 0 within 43..83", kif.key_valid, n);
    end
    checks = checks + 1;
    if (kif.key_code !== 5'b00101) begin
      errors = errors + 1;
      $display("FAIL key5_code_after_release: got %b expected 00101", kif.key_code);
    end
  endtask

  task automatic test_bounce();
    int n;
    int rises_before;
    wait_col_start(5'b11110);
    rises_before = rises;
    repeat (6) begin
      pressed[18] = 1'b1;
      repeat (20) @(negedge clk);
      pressed[18] = 1'b0;
      repeat (20) @(negedge clk);
    end
    checks = checks + 1;
    if (rises !== rises_before || kif.key_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL bounce_no_press: rises=%0d valid=%b, required %0d/0", rises, kif.key_valid, rises_before);
    end
    pressed[18] = 1'b1;
    exp_q.push_back(5'b10011);
    wait_valid(1'b1, 90, n);
    checks = checks + 1;
    if (kif.key_valid !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL enter_rise_timeout: valid=%b after %0d cycles, required 1", kif.key_valid, n);
    end
    pressed = 20'd0;
    wait_valid(1'b0, 90, n);
    checks = checks + 1;
    if (kif.key_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL enter_release_timeout: valid=%b after %0d cycles, required 0", kif.key_valid, n);
    end
  endtask

  task automatic test_second_key_held();
    int n;
    logic dropped;
    wait_col_start(5'b11110);
    pressed[0] = 1'b1;
    exp_q.push_back(5'b00111);
    wait_valid(1'b1, 70, n);
    checks = checks + 1;
    if (kif.key_valid !== 1'b1 || n < 43 || n > 63) begin
      errors = errors + 1;
      $display("FAIL key7_rise_latency: valid=%b after %0d cycles, required 43..63", kif.key_valid, n);
    end
    pressed[2] = 1'b1;
    dropped = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (kif.key_valid !== 1'b1 || kif.key_code !== 5'b00111) dropped = 1'b1;
    end
    checks = checks + 1;
    if (dropped !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL key7_plus9_hold: dropped=%b, required 0 (valid=1, code 00111)", dropped);
    end
    wait_col_start(5'b11110);
    pressed = 20'd0;
    wait_valid(1'b0, 90, n);
    checks = checks + 1;
    if (kif.key_valid !== 1'b0 || n < 43 || n > 83) begin
      errors = errors + 1;
      $display("FAIL key7_release: valid=%b after %0d cycles, required 0 within 43..83", kif.key_valid, n);
    end
  endtask

  task automatic test_multi_from_idle();
    int n;
    int rises_before;
    wait_col_start(5'b11110);
    rises_before = rises;
    pressed[0]  = 1'b1;
    pressed[10] = 1'b1;
    repeat (120) @(negedge clk);
    checks = checks + 1;
    if (rises !== rises_before || kif.key_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL multi_no_press: rises=%0d valid=%b, required %0d/0", rises, kif.key_valid, rises_before);
    end
    wait_col_start(5'b11110);
    pressed[10] = 1'b0;
    exp_q.push_back(5'b00111);
    wait_valid(1'b1, 70, n);
    checks = checks + 1;
    if (kif.key_valid !== 1'b1 || n < 43 || n > 63) begin
      errors = errors + 1;
      $display("FAIL multi_then_7_latency: valid=%b after %0d cycles, required 43..63", kif.key_valid, n);
    end
  endtask

  task automatic test_reset_pressed();
    int n;
    rst = 1'b1;
    @(negedge clk);
    checks = checks + 3;
    if (kif.key_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL midreset_key_valid: got %b expected 0", kif.key_valid);
    end
    if (kif.col_n !== 5'b11110) begin
      errors = errors + 1;
      $display("FAIL midreset_col_n: got %b expected 11110", kif.col_n);
    end
    if (kif.key_code !== CODE_NOP) begin
      errors = errors + 1;
      $display("FAIL midreset_key_code: got %b expected %b", kif.key_code, CODE_NOP);
    end
    rst = 1'b0;
    exp_q.push_back(5'b00111);
    wait_valid(1'b1, 70, n);
    checks = checks + 1;
    if (kif.key_valid !== 1'b1 || n < 43 || n > 63) begin
      errors = errors + 1;
      $display("FAIL reaccept_latency: valid=%b after %0d cycles, required 43..63", kif.key_valid, n);
    end
    pressed = 20'd0;
    wait_valid(1'b0, 90, n);
    checks = checks + 1;
    if (kif.key_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reaccept_release_timeout: valid=%b after %0d cycles, required 0", kif.key_valid, n);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_second_key_held();
    test_multi_from_idle();
    test_reset_pressed();
    repeat (100) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL pending_presses: %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
